// File: rtl/seq_feed_pkg.sv
// Shared types and constants for the sequence-detector run controller.
package seq_feed_pkg;

  localparam int LEN_W = 5;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] HIT_SAT = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_WAIT   = 3'd2,
    S_STEP   = 3'd3,
    S_SAMPLE = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == HIT_SAT) ? v : v + 4'd1;
  endfunction

  function automatic logic is_busy(input state_e s);
    return (s == S_CLEAR) || (s == S_WAIT) || (s == S_STEP) || (s == S_SAMPLE);
  endfunction

endpackage

// File: rtl/seq_feed_if.sv
// Run-request and detector-side signals of the feed controller.
interface seq_feed_if
  import seq_feed_pkg::*;
#(
  parameter int MAX_LEN = 16
);
  logic               start;
  logic               abort;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   length;
  logic               det_hit;
  logic               det_bit;
  logic               det_step;
  logic               det_clr;
  logic               busy;
  logic               done;
  logic               err;
  logic [CNT_W-1:0]   hit_count;
  logic [LEN_W-1:0]   bit_idx;

  modport master (
    output start, abort, pattern, length, det_hit,
    input  det_bit, det_step, det_clr, busy, done, err, hit_count, bit_idx
  );

  modport slave (
    input  start, abort, pattern, length, det_hit,
    output det_bit, det_step, det_clr, busy, done, err, hit_count, bit_idx
  );
endinterface

// File: rtl/seq_feed_ctrl_pace_tick.sv
// Loadable down-counter that paces the detector steps; tc_o flags zero.
module pace_tick #(
  parameter int PACE_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int W = (PACE_DIV > 1) ? $clog2(PACE_DIV) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(PACE_DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // next count: load wins, otherwise decrement down to zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (en_i && (cnt_q != {W{1'b0}})) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == {W{1'b0}});
endmodule

// File: rtl/seq_feed_ctrl.sv
// Feeds a latched bit pattern into the sequence detector at a paced rate and
// counts the detector's hits; start/busy/done handshake towards the host.
module seq_feed_ctrl
  import seq_feed_pkg::*;
#(
  parameter int MAX_LEN  = 16,
  parameter int PACE_DIV = 25_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  seq_feed_if.slave  bus
);
  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   hit_q, hit_d;
  logic               err_q, err_d;
  logic               det_bit_q, det_bit_d;
  logic               det_step_q, det_clr_q, busy_q, done_q;
  logic               cnt_load_s, cnt_en_s, cnt_tc_s, len_ok_s;
  logic [LEN_W-1:0]   idx_inc_s, sel_s;

  pace_tick #(.PACE_DIV(PACE_DIV)) u_pace (
    .clk_i  (CLOCK_50),
    .rst_i  (reset),
    .load_i (cnt_load_s),
    .en_i   (cnt_en_s),
    .tc_o   (cnt_tc_s)
  );

  assign len_ok_s  = (bus.length != 5'd0) && (bus.length <= LEN_W'(MAX_LEN));
  assign idx_inc_s = idx_q + 5'd1;

  // next-state, run bookkeeping and the bit presented to the detector
  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    len_d      = len_q;
    idx_d      = idx_q;
    hit_d      = hit_q;
    err_d      = err_q;
    cnt_load_s = 1'b0;
    cnt_en_s   = 1'b0;
    det_bit_d  = det_bit_q;
    sel_s      = 5'd0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && len_ok_s) begin
          pattern_d = bus.pattern;
          len_d     = bus.length;
          err_d     = 1'b0;
          state_d   = S_CLEAR;
        end else if (bus.start) begin
          err_d   = 1'b1;
          hit_d   = 4'd0;
          state_d = S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (bus.abort) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          hit_d      = 4'd0;
          idx_d      = 5'd0;
          cnt_load_s = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.abort) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (cnt_tc_s) begin
          state_d = S_STEP;
        end else begin
          cnt_en_s = 1'b1;
        end
      end
      S_STEP: begin
        if (bus.abort) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (bus.abort) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          // the detector updated on the step edge, so its Moore output is current
          if (bus.det_hit) begin
            hit_d = sat_inc(hit_q);
          end else begin
            hit_d = hit_q;
          end
          idx_d = idx_inc_s;
          if (idx_inc_s == len_q) begin
            state_d = S_DONE;
          end else begin
            cnt_load_s = 1'b1;
            state_d    = S_WAIT;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // MSB-first: the bit for step n is pattern[length-1-n], refreshed on WAIT entry
    if (state_d == S_WAIT) begin
      sel_s     = len_q - 5'd1 - idx_d;
      det_bit_d = |(pattern_q & ({{(MAX_LEN-1){1'b0}}, 1'b1} << sel_s));
    end else begin
      det_bit_d = det_bit_q;
    end
  end

  // state, run data and output strobes; strobes decode the next state so they align with it
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pattern_q  <= {MAX_LEN{1'b0}};
      len_q      <= 5'd0;
      idx_q      <= 5'd0;
      hit_q      <= 4'd0;
      err_q      <= 1'b0;
      det_bit_q  <= 1'b0;
      det_step_q <= 1'b0;
      det_clr_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pattern_q  <= pattern_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      hit_q      <= hit_d;
      err_q      <= err_d;
      det_bit_q  <= det_bit_d;
      det_step_q <= (state_d == S_STEP);
      det_clr_q  <= (state_d == S_CLEAR);
      busy_q     <= is_busy(state_d);
      done_q     <= (state_d == S_DONE);
    end
  end

  assign bus.det_bit   = det_bit_q;
  assign bus.det_step  = det_step_q;
  assign bus.det_clr   = det_clr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.hit_count = hit_q;
  assign bus.bit_idx   = idx_q;
endmodule

// File: tb/tb_seq_feed_ctrl.sv
// Table-driven bench for seq_feed_ctrl with a behavioural 1100111 Moore detector.
module tb_seq_feed_ctrl;
  import seq_feed_pkg::*;

  typedef struct {
    string       tag;
    logic [15:0] pattern;
    logic [4:0]  length;
    logic        tie;
    int          exp_done;
    int          exp_hits;
    logic        exp_err;
    int          exp_steps;
    int          exp_clr;
    logic [15:0] exp_bits;
    logic [15:0] exp_mask;
    int          exp_idx;
    int          poke;
    int          abort_at;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic tie_hit;
  int   checks = 0;
  int   failures = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  seq_feed_if #(.MAX_LEN(16)) bus();

  seq_feed_ctrl #(.MAX_LEN(16), .PACE_DIV(2)) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus.slave)
  );

  // detector model: last seven stepped bits plus a fill count
  logic [6:0] hist;
  logic [2:0] seen;
  always @(posedge clk or posedge rst) begin
    if (rst || bus.det_clr) begin
      hist <= 7'd0;
      seen <= 3'd0;
    end else if (bus.det_step) begin
      hist <= {hist[5:0], bus.det_bit};
      if (seen != 3'd7) seen <= seen + 3'd1;
    end
  end
  assign bus.det_hit = tie_hit ? 1'b1 : ((seen == 3'd7) && (hist == 7'b1100111));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string tag, input logic [15:0] p, input logic [4:0] l,
                              input logic t, input int dn, input int hits, input logic e,
                              input int st, input int cl, input logic [15:0] b,
                              input logic [15:0] m, input int idx, input int pk, input int ab);
    vec_t v;
    v.tag = tag; v.pattern = p; v.length = l; v.tie = t; v.exp_done = dn;
    v.exp_hits = hits; v.exp_err = e; v.exp_steps = st; v.exp_clr = cl;
    v.exp_bits = b; v.exp_mask = m; v.exp_idx = idx; v.poke = pk; v.abort_at = ab;
    return v;
  endfunction

  // called at a negedge: start is accepted at the next posedge (edge 0)
  task automatic run_vec(input vec_t v);
    int cyc = 0;
    int steps = 0;
    int clrs = 0;
    logic [15:0] bits = 16'd0;
    logic [15:0] mask = 16'd0;
    logic prev_step = 1'b0;
    logic seen_done = 1'b0;
    bus.pattern = v.pattern;
    bus.length  = v.length;
    bus.start   = 1'b1;
    bus.abort   = 1'b0;
    tie_hit     = v.tie;
    while (!seen_done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        bus.pattern = ~v.pattern;
        bus.length  = 5'd0;
      end
      if (prev_step) mask = mask | (16'(bus.det_hit) << (steps - 1));
      prev_step = bus.det_step;
      if (bus.det_clr) clrs++;
      if (bus.det_step) begin
        steps++;
        bits = {bits[14:0], bus.det_bit};
      end
      if (bus.done) begin
        seen_done = 1'b1;
      end else begin
        bus.start = (cyc == v.poke);
        bus.abort = (cyc == v.abort_at);
      end
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    if (!seen_done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: no done in 200 cycles, required at cycle %0d", v.tag, v.exp_done);
    end
    check({v.tag, "_done_cycle"}, cyc, v.exp_done);
    check({v.tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    check({v.tag, "_err"}, 32'(bus.err), 32'(v.exp_err));
    check({v.tag, "_hit_count"}, 32'(bus.hit_count), v.exp_hits);
    check({v.tag, "_steps"}, steps, v.exp_steps);
    check({v.tag, "_clears"}, clrs, v.exp_clr);
    check({v.tag, "_bit_seq"}, 32'(bits), 32'(v.exp_bits));
    check({v.tag, "_hit_mask"}, 32'(mask), 32'(v.exp_mask));
    if (v.exp_idx >= 0) check({v.tag, "_bit_idx"}, 32'(bus.bit_idx), v.exp_idx);
  endtask

  initial begin
    //                 pattern   len    tie  done hits err steps clr bits      mask      idx poke abort
    tbl.push_back(mk("p67",   16'h0067, 5'd7,  1'b0, 30, 1,  1'b0, 7,  1, 16'h0067, 16'h0040, 7,  0, 0));
    tbl.push_back(mk("len0",  16'h0067, 5'd0,  1'b0, 1,  0,  1'b1, 0,  0, 16'h0000, 16'h0000, -1, 0, 0));
    tbl.push_back(mk("ovl",   16'h19E7, 5'd13, 1'b0, 54, 2,  1'b0, 13, 1, 16'h19E7, 16'h1040, 13, 0, 0));
    tbl.push_back(mk("len17", 16'h00FF, 5'd17, 1'b0, 1,  0,  1'b1, 0,  0, 16'h0000, 16'h0000, -1, 0, 0));
    tbl.push_back(mk("abort", 16'h0067, 5'd7,  1'b0, 15, 0,  1'b1, 3,  1, 16'h0006, 16'h0000, 3,  0, 14));
    tbl.push_back(mk("poke",  16'h0067, 5'd2,  1'b0, 10, 0,  1'b0, 2,  1, 16'h0003, 16'h0000, 2,  3, 0));
    tbl.push_back(mk("sat",   16'hFFFF, 5'd16, 1'b1, 66, 15, 1'b0, 16, 1, 16'hFFFF, 16'hFFFF, 16, 0, 0));
    tbl.push_back(mk("len1",  16'h0067, 5'd1,  1'b0, 6,  0,  1'b0, 1,  1, 16'h0001, 16'h0000, 1,  0, 0));

    rst = 1'b1;
    tie_hit = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.pattern = 16'd0;
    bus.length = 5'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_step_clr", 32'({bus.det_step, bus.det_clr, bus.det_bit}), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_hits_idx", 32'({bus.hit_count, bus.bit_idx}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // each run starts in the IDLE cycle right after the previous done
    foreach (tbl[i]) begin
      run_vec(tbl[i]);
      @(negedge clk);
      check({tbl[i].tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
      check({tbl[i].tag, "_idle_no_step"}, 32'({bus.busy, bus.det_step}), 32'd0);
    end

    // reset in the WAIT of bit 3 of a saturating run
    bus.pattern = 16'hFFFF;
    bus.length = 5'd16;
    tie_hit = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    check("pre_rst_hits", 32'(bus.hit_count), 32'd2);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_step_done", 32'({bus.det_step, bus.done}), 32'd0);
    check("mid_rst_hits_idx", 32'({bus.hit_count, bus.bit_idx}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tie_hit = 1'b0;
    @(negedge clk);
    tbl[0].tag = "after_rst";
    run_vec(tbl[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
